spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares one spi_master among NREQ local requesters using round-robin arbitration.
- For each transfer: latches the winner's transmit word, issues the one-clock start pulse, tracks the master's LOAD framing signal, captures the received word and returns it to the winner with a one-cycle done pulse.
- Sits between on-chip clients and spi_master; replaces the free-running Gen_st strobe.
- A timeout guard recovers the block if the master never frames a transfer.

Parameters:
- M, 9, SPI word width in bits; must equal spi_master m.
- NREQ, 4, number of requesters, 2..8.
- TIMEOUT, 4096, max clk cycles spent in WAIT_LO plus WAIT_HI before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level; must stay high until that requester's done pulse.
- tx_dat  in  NREQ*M  flattened transmit words; requester i uses bits [i*M+M-1 : i*M].
- grant  out  NREQ  one-hot owner of the current transfer, 0 when idle.
- done  out  NREQ  one-hot, one-cycle completion pulse to the owner.
- rx_dat  out  M  received word; valid while done is nonzero, held until the next capture.
- err  out  1  high together with done when the transfer ended by timeout.
- m_st  out  1  start pulse to spi_master st.
- m_di  out  M  transmit word to spi_master DI.
- m_load  in  1  spi_master LOAD: high when idle, low while a frame is in progress.
- m_do  in  M  spi_master DO.

Behaviour:
- Reset (async assert, sync release): state=IDLE; grant=0, done=0, rx_dat=0, err=0, m_st=0, m_di=0; rr pointer=NREQ-1, so requester 0 has first priority; timeout counter=0.
- States: IDLE, START, WAIT_LO, WAIT_HI, DONE.
- IDLE:
  - If req!=0, select the first set bit searching from pointer+1 upward with wrap.
  - Next cycle: state=START, grant=onehot(winner), m_di=tx_dat slice of winner, pointer=winner.
  - If req=0, remain in IDLE.
- START: m_st=1 for exactly this cycle. Next state is WAIT_LO and the counter clears.
- WAIT_LO:
  - Wait for m_load=0, then go to WAIT_HI.
  - Counter increments each cycle in WAIT_LO and WAIT_HI.
- WAIT_HI:
  - When m_load=1 is sampled: rx_dat<=m_do, err<=0, state=DONE.
- Timeout:
  - If the counter reaches TIMEOUT in WAIT_LO or WAIT_HI: rx_dat unchanged, err<=1, state=DONE.
  - Timeout takes priority over a same-cycle m_load event.
- DONE:
  - done=grant for one cycle. err is held for the same cycle and then cleared.
  - Next cycle: grant=0, state=IDLE.
  - The next arbitration occurs in that IDLE cycle, so there is at least one idle cycle between transfers.
- Fixed latencies:
  - req rises in IDLE at cycle t: grant and m_di at t+1, m_st high at t+2.
  - m_load rise sampled at cycle u: done and rx_dat valid at u+1.
- m_di and grant are stable from START through DONE.
- tx_dat and req changes during a transfer are ignored.
- A requester dropping req mid-transfer does not abort the transfer; done is still pulsed to it.
- Fairness: a continuously requesting client waits at most NREQ-1 transfers.
- Multiple simultaneous requests are resolved purely by the pointer; there is no fixed priority.
- Reset mid-transfer: all outputs return to reset values at once. The master may finish its frame unobserved. After release the arbiter begins only from IDLE, and a stale m_load rise is ignored because the state is not WAIT_HI.
- m_load is assumed synchronous to clk; no synchronizer is used.

Test Plan:
- Single transfer, M=9, slave model loopback returning 9'h1DB, req[1]=1 with tx word 9'h17A:
  - m_st pulses once two cycles after req.
  - m_di=9'h17A.
  - done=4'b0010 for one cycle with rx_dat=9'h1DB, err=0.
- All four req high from reset, held until each respective done:
  - Grant order is 0,1,2,3.
  - Exactly four m_st pulses.
  - One idle cycle between DONE and the next START.
- Fairness, req[0] and req[2] both held permanently: grant alternates 0,2,0,2 across six transfers; requesters 1 and 3 are never granted.
- Timeout, TIMEOUT=16, m_load tied high, req[3]=1:
  - done=4'b1000 with err=1 exactly 16 cycles after entering WAIT_LO.
  - rx_dat keeps its previous value.
  - A following normal transfer reports err=0.
- Reset mid-operation, assert rst_n=0 during WAIT_HI:
  - grant, done, m_st, m_di and rx_dat go to 0 asynchronously.
  - After release with req[0]=1, the next grant is requester 0.
- Request drop: req[2] deasserted during WAIT_HI → done[2] still pulses, and no new grant is issued while req=0.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin front end that shares one spi_master among NREQ
// clients. It latches the winner's word, pulses start, follows LOAD framing,
// returns the received word with a one-cycle done pulse, and aborts with err
// if the master never frames the transfer.
module spi_txn_arbiter #(
    parameter int unsigned M       = 9,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*M-1:0] tx_dat,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [M-1:0]      rx_dat,
    output logic              err,
    output logic              m_st,
    output logic [M-1:0]      m_di,
    input  logic              m_load,
    input  logic [M-1:0]      m_do
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    // Abort on the edge where the counter would reach TIMEOUT, so done lands
    // exactly TIMEOUT cycles after entering WAIT_LO.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLo,
        StWaitHi,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [M-1:0]      m_di_q, m_di_d;
    logic [M-1:0]      rx_dat_q, rx_dat_d;
    logic              err_q, err_d;
    logic              m_st_q, m_st_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [PtrW-1:0]   winner;
    logic              found;
    logic              timeout;
    int                idx;

    // Round-robin search starting just above the last winner, with wrap.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PtrW'(idx);
            end
        end
    end

    assign timeout = (cnt_q == CntLast);

    // Next-state and datapath updates for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        m_di_d   = m_di_q;
        rx_dat_d = rx_dat_q;
        err_d    = err_q;
        m_st_d   = 1'b0;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StStart;
                    grant_d = NREQ'(1) << winner;
                    m_di_d  = tx_dat[int'(winner)*M +: M];
                    ptr_d   = winner;
                end
            end
            StStart: begin
                // Start is registered, so the master sees it one cycle later.
                m_st_d  = 1'b1;
                cnt_d   = '0;
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (!m_load) begin
                        state_d = StWaitHi;
                    end
                end
            end
            StWaitHi: begin
                // Timeout wins over a same-cycle LOAD rise.
                if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (m_load) begin
                        rx_dat_d = m_do;
                        err_d    = 1'b0;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; everything returns to idle on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            m_di_q   <= '0;
            rx_dat_q <= '0;
            err_q    <= 1'b0;
            m_st_q   <= 1'b0;
            ptr_q    <= PtrW'(NREQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            m_di_q   <= m_di_d;
            rx_dat_q <= rx_dat_d;
            err_q    <= err_d;
            m_st_q   <= m_st_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant  = grant_q;
    assign done   = (state_q == StDone) ? grant_q : '0;
    assign rx_dat = rx_dat_q;
    assign err    = err_q;
    assign m_st   = m_st_q;
    assign m_di   = m_di_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a small behavioural spi_master.
module tb_spi_txn_arbiter;

    localparam int M    = 9;
    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*M-1:0] tx_dat;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [M-1:0]      rx_dat;
    logic              err;
    logic              m_st;
    logic [M-1:0]      m_di;
    logic              m_load;
    logic [M-1:0]      m_do;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int st_count = 0;
    logic fair_mon = 1'b0;
    logic bad_grant = 1'b0;

    // Master model controls.
    logic         slave_en = 1'b1;
    logic [M-1:0] reply    = '0;
    int           busy;

    spi_txn_arbiter #(.M(M), .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .tx_dat (tx_dat),
        .grant  (grant),
        .done   (done),
        .rx_dat (rx_dat),
        .err    (err),
        .m_st   (m_st),
        .m_di   (m_di),
        .m_load (m_load),
        .m_do   (m_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame: LOAD low for several cycles after start, then high with reply.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_load <= 1'b1;
            m_do   <= '0;
            busy   <= 0;
        end else if (busy == 0) begin
            if (m_st && slave_en) begin
                m_load <= 1'b0;
                busy   <= 6;
            end
        end else begin
            busy <= busy - 1;
            if (busy == 1) begin
                m_load <= 1'b1;
                m_do   <= reply;
            end
        end
    end

    always @(negedge clk) begin
        if (m_st) st_count <= st_count + 1;
        if (fair_mon && (grant & 4'b1010) != 0) bad_grant <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, output logic [M-1:0] r,
                             output logic e, output int c);
        int n;
        n = 0;
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("done_wait_bound", 32'd0, 32'd1);
        d = done;
        r = rx_dat;
        e = err;
        c = cyc;
    endtask

    task automatic wait_mload_low();
        int n;
        n = 0;
        while (m_load && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("mload_wait_bound", 32'd0, 32'd1);
    endtask

    logic [NREQ-1:0] d;
    logic [M-1:0]    r;
    logic            e;
    int              c, c_st, t0, st0, n;
    logic [NREQ-1:0] exp_g;

    initial begin
        rst_n  = 1'b0;
        req    = '0;
        tx_dat = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_rx", 32'(rx_dat), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_mst", 32'(m_st), 32'h0);
        check_eq("rst_mdi", 32'(m_di), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transfer, requester 1.
        reply = 9'h1DB;
        tx_dat[1*M +: M] = 9'h17A;
        req = 4'b0010;
        t0 = cyc;
        st0 = st_count;
        @(negedge clk);
        check_eq("t1_grant", 32'(grant), 32'h2);
        check_eq("t1_mdi", 32'(m_di), 32'h17A);
        check_eq("t1_mst_early", 32'(m_st), 32'h0);
        @(negedge clk);
        check_eq("t1_mst", 32'(m_st), 32'h1);
        check_eq("t1_mst_lat", 32'(cyc - t0), 32'd2);
        wait_done(d, r, e, c);
        check_eq("t1_done", 32'(d), 32'h2);
        check_eq("t1_rx", 32'(r), 32'h1DB);
        check_eq("t1_err", 32'(e), 32'h0);
        req = '0;
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(done), 32'h0);
        repeat (4) @(negedge clk);
        check_eq("t1_st_count", 32'(st_count - st0), 32'd1);

        // All four requesting from reset: order 0,1,2,3 with idle gaps.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reply = 9'h0C3;
        st0 = st_count;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_done(d, r, e, c);
            exp_g = 4'(1 << i);
            check_eq($sformatf("all_done%0d", i), 32'(d), 32'(exp_g));
            req[i] = 1'b0;
            @(negedge clk);
            check_eq($sformatf("all_gap%0d", i), 32'(grant), 32'h0);
            if (i < 3) begin
                @(negedge clk);
                check_eq($sformatf("all_next%0d", i), 32'(grant), 32'(exp_g << 1));
            end
        end
        repeat (3) @(negedge clk);
        check_eq("all_st_count", 32'(st_count - st0), 32'd4);

        // Fairness: 0 and 2 held; pointer is at 3 so 0 goes first.
        reply = 9'h0A5;
        fair_mon = 1'b1;
        req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            wait_done(d, r, e, c);
            check_eq($sformatf("fair_done%0d", i), 32'(d), (i % 2 == 0) ? 32'h1 : 32'h4);
            if (i == 5) req = '0;
            @(negedge clk);
        end
        fair_mon = 1'b0;
        check_eq("fair_no_1_3", 32'(bad_grant), 32'h0);
        repeat (3) @(negedge clk);

        // Timeout: master never frames.
        slave_en = 1'b0;
        req = 4'b1000;
        n = 0;
        while (!m_st && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("to_mst_bound", 32'd0, 32'd1);
        c_st = cyc;
        wait_done(d, r, e, c);
        check_eq("to_done", 32'(d), 32'h8);
        check_eq("to_err", 32'(e), 32'h1);
        check_eq("to_rx_held", 32'(r), 32'h0A5);
        check_eq("to_latency", 32'(c - c_st), 32'd16);
        req = '0;
        @(negedge clk);
        check_eq("to_err_clr", 32'(err), 32'h0);
        slave_en = 1'b1;
        reply = 9'h055;
        req = 4'b0001;
        wait_done(d, r, e, c);
        check_eq("after_to_done", 32'(d), 32'h1);
        check_eq("after_to_err", 32'(e), 32'h0);
        check_eq("after_to_rx", 32'(r), 32'h055);
        req = '0;
        repeat (3) @(negedge clk);

        // Reset while in WAIT_HI; pointer last at 0.
        tx_dat[0*M +: M] = 9'h133;
        req = 4'b0001;
        wait_mload_low();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_grant", 32'(grant), 32'h0);
        check_eq("mid_rst_done", 32'(done), 32'h0);
        check_eq("mid_rst_mst", 32'(m_st), 32'h0);
        check_eq("mid_rst_mdi", 32'(m_di), 32'h0);
        check_eq("mid_rst_rx", 32'(rx_dat), 32'h0);
        @(negedge clk);
        req = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("post_rst_grant", 32'(grant), 32'h1);
        wait_done(d, r, e, c);
        req[0] = 1'b0;
        @(negedge clk);
        wait_done(d, r, e, c);
        check_eq("post_rst_second", 32'(d), 32'h2);
        req = '0;
        repeat (3) @(negedge clk);

        // Request dropped during WAIT_HI still completes.
        reply = 9'h1E1;
        req = 4'b0100;
        wait_mload_low();
        @(negedge clk);
        req = '0;
        wait_done(d, r, e, c);
        check_eq("drop_done", 32'(d), 32'h4);
        check_eq("drop_rx", 32'(r), 32'h1E1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant != '0) n++;
        end
        check_eq("drop_no_grant", 32'(n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
